// File: rtl/morse_sequencer.sv
// Queued Morse playback of letters A-H onto a single LED. Letters are pushed into a
// circular queue and, once started, shifted out one pattern bit per divider tick.
module morse_sequencer #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [2:0]             wr_data,
  input  logic                   start,
  input  logic                   abort,
  output logic                   led,
  output logic                   busy,
  output logic                   done,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam logic [DivW-1:0] DivReload = DivW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntFull   = CntW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StGap, StDone} state_t;

  state_t            state_q;
  logic [DivW-1:0]   div_q;
  logic [11:0]       shreg_q;
  logic [3:0]        bits_q;
  logic [1:0]        units_q;
  logic              led_q;
  logic              busy_q;
  logic              done_q;

  logic [2:0]        mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [CntW-1:0]   count_d;
  logic              full_q;
  logic              ovf_q;

  logic              tick;
  logic              push;
  logic              pop;
  logic [11:0]       rom_pat;
  logic [3:0]        rom_len;

  assign tick = (div_q == '0);
  assign push = wr_en && !abort && !full_q;
  // Entry to LOAD always implies a non-empty queue; the guard keeps the pointers sane anyway.
  assign pop  = (state_q == StLoad) && !abort && (count_q != '0);

  // Patterns are left-aligned so the element currently on the LED is always bit 11.
  always_comb begin
    rom_pat = 12'h000;
    rom_len = 4'd0;
    unique case (mem[rd_ptr_q])
      3'd0: begin rom_pat = 12'hB80; rom_len = 4'd5;  end
      3'd1: begin rom_pat = 12'hEA8; rom_len = 4'd9;  end
      3'd2: begin rom_pat = 12'hEBA; rom_len = 4'd11; end
      3'd3: begin rom_pat = 12'hEA0; rom_len = 4'd7;  end
      3'd4: begin rom_pat = 12'h800; rom_len = 4'd1;  end
      3'd5: begin rom_pat = 12'hAE8; rom_len = 4'd9;  end
      3'd6: begin rom_pat = 12'hEE8; rom_len = 4'd9;  end
      3'd7: begin rom_pat = 12'hAA0; rom_len = 4'd7;  end
      default: begin rom_pat = 12'h000; rom_len = 4'd0; end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (abort) begin
      // Flush only; the overflow flag survives an abort.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_en && full_q) begin
        ovf_q <= 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == CntFull);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      shreg_q <= '0;
      bits_q  <= '0;
      units_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      state_q <= StIdle;
      div_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && (count_q != '0)) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          shreg_q <= rom_pat;
          bits_q  <= rom_len;
          div_q   <= DivReload;
          led_q   <= rom_pat[11];
          state_q <= StShift;
        end
        StShift: begin
          if (tick) begin
            div_q   <= DivReload;
            shreg_q <= {shreg_q[10:0], 1'b0};
            bits_q  <= bits_q - 4'd1;
            if (bits_q == 4'd1) begin
              state_q <= StGap;
              units_q <= 2'd3;
              led_q   <= 1'b0;
            end else begin
              led_q <= shreg_q[10];
            end
          end else begin
            div_q <= div_q - 1'b1;
            led_q <= shreg_q[11];
          end
        end
        StGap: begin
          if (tick) begin
            div_q   <= DivReload;
            units_q <= units_q - 2'd1;
            if (units_q == 2'd1) begin
              if (count_q != '0) begin
                state_q <= StLoad;
              end else begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign led   = led_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign full  = full_q;
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: directed scenarios plus a letter scoreboard that is fed by
// accepted pushes and drained by a monitor decoding the LED waveform.
module tb_morse_sequencer;

  localparam int TD = 4;
  localparam int DP = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_data = 3'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       led;
  logic       busy;
  logic       done;
  logic       full;
  logic [$clog2(DP):0] count;
  logic       ovf;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];
  logic       m_ovf = 1'b0;

  morse_sequencer #(.TICK_DIV(TD), .DEPTH(DP)) dut (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .start   (start),
    .abort   (abort),
    .led     (led),
    .busy    (busy),
    .done    (done),
    .full    (full),
    .count   (count),
    .ovf     (ovf)
  );

  always #5 clock = ~clock;

  // Right-aligned element patterns and their lengths.
  function automatic logic [10:0] ref_bits(input logic [2:0] l);
    case (l)
      3'd0: return 11'b10111;
      3'd1: return 11'b111010101;
      3'd2: return 11'b11101011101;
      3'd3: return 11'b1110101;
      3'd4: return 11'b1;
      3'd5: return 11'b101011101;
      3'd6: return 11'b111011101;
      default: return 11'b1010101;
    endcase
  endfunction

  function automatic int ref_len(input logic [2:0] l);
    case (l)
      3'd0: return 5;
      3'd1: return 9;
      3'd2: return 11;
      3'd3: return 7;
      3'd4: return 1;
      3'd5: return 9;
      3'd6: return 9;
      default: return 7;
    endcase
  endfunction

  // Monitor: capture LED from the first high cycle until a 3-unit low run closes the letter.
  logic [63:0] cap_vec;
  int          cap_len = 0;
  int          zrun = 0;
  int          mon_n;
  int          mon_len;
  logic [2:0]  mon_l;
  logic [10:0] mon_pat;
  logic        mon_ok;

  always @(negedge clock) begin
    if (!reset || !busy) begin
      cap_len = 0;
      zrun    = 0;
      cap_vec = '0;
    end else if (led || cap_len > 0) begin
      if (cap_len < 64) cap_vec[cap_len] = led;
      cap_len++;
      zrun = led ? 0 : zrun + 1;
      if (zrun == 3 * TD) begin
        mon_n = cap_len - 3 * TD;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL letter_extra: got a %0d-cycle letter, required none", mon_n);
        end else begin
          mon_l   = exp_q.pop_front();
          mon_pat = ref_bits(mon_l);
          mon_len = ref_len(mon_l);
          mon_ok  = (mon_n == mon_len * TD);
          if (mon_ok) begin
            for (int i = 0; i < mon_n; i++) begin
              if (cap_vec[i] !== mon_pat[mon_len - 1 - i / TD]) mon_ok = 1'b0;
            end
          end
          if (!mon_ok) begin
            errors++;
            $display("FAIL letter_%c: got %0d cycles %b, required %0d cycles of pattern %b",
                     8'd65 + {5'd0, mon_l}, mon_n, cap_vec, mon_len * TD, mon_pat);
          end
        end
        cap_len = 0;
        zrun    = 0;
        cap_vec = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [2:0] l);
    wr_en   = 1'b1;
    wr_data = l;
    if (exp_q.size() < DP) exp_q.push_back(l);
    else m_ovf = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_for_done(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({led, busy, done, full, count, ovf} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: led/busy/done/full/count/ovf=%b%b%b%b_%0d_%b required all 0",
               led, busy, done, full, count, ovf);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL reset_release: busy=%b count=%0d required 0 0", busy, count);
    end
  endtask

  task automatic test_single_letter();
    logic el, ed, eb;
    push(3'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      el = (c >= 2 && c <= 5);
      ed = (c == 18);
      eb = (c <= 18);
      checks++;
      if ({led, done, busy} !== {el, ed, eb}) begin
        errors++;
        $display("FAIL single_E T+%0d: led/done/busy=%b%b%b required %b%b%b",
                 c, led, done, busy, el, ed, eb);
      end
      if (c < 19) tick();
    end
  endtask

  task automatic test_two_letters();
    logic [2:0]  seq [2];
    logic        tl[$];
    logic [10:0] pat;
    int          len;
    seq[0] = 3'd0;
    seq[1] = 3'd4;
    push(seq[0]);
    push(seq[1]);
    tl.push_back(1'b0);
    for (int k = 0; k < 2; k++) begin
      pat = ref_bits(seq[k]);
      len = ref_len(seq[k]);
      for (int b = len - 1; b >= 0; b--)
        for (int r = 0; r < TD; r++) tl.push_back(pat[b]);
      for (int r = 0; r < 3 * TD; r++) tl.push_back(1'b0);
      if (k == 0) tl.push_back(1'b0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < tl.size(); c++) begin
      checks++;
      if (led !== tl[c] || done !== 1'b0) begin
        errors++;
        $display("FAIL two_letters T+%0d: led=%b done=%b required led=%b done=0",
                 c + 1, led, done, tl[c]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL two_letters_done: done=%b busy=%b required 1 1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL two_letters_idle: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_queue_bounds();
    logic seen;
    for (int i = 0; i < 5; i++) begin
      push(3'(i));
      checks++;
      if (count !== 3'(exp_q.size()) || full !== (exp_q.size() == DP) || ovf !== m_ovf) begin
        errors++;
        $display("FAIL queue_write%0d: count=%0d full=%b ovf=%b required %0d %b %b",
                 i, count, full, ovf, exp_q.size(), exp_q.size() == DP, m_ovf);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_for_done(600, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL queue_done: done=0 after 600 cycles, required a pulse");
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_played: %0d letters unplayed, required 0", exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    logic seen;
    push(3'd6);
    start = 1'b1;
    tick();
    start = 1'b0;
    push(3'd5);
    checks++;
    if (count !== 3'd1) begin
      errors++;
      $display("FAIL load_write_count: count=%0d required 1", count);
    end
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || count !== 3'd1) begin
      errors++;
      $display("FAIL start_in_shift: busy=%b count=%0d required 1 1", busy, count);
    end
    wait_for_done(400, seen);
    checks++;
    if (!seen || exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_done: done_seen=%b unplayed=%0d required 1 0", seen, exp_q.size());
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_idle: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_abort();
    logic bad;
    push(3'd2);
    push(3'd0);
    push(3'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    abort   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 3'd7;
    tick();
    abort = 1'b0;
    wr_en = 1'b0;
    exp_q.delete();
    checks++;
    if ({led, busy, done, full} !== 4'b0 || count !== '0 || ovf !== m_ovf) begin
      errors++;
      $display("FAIL abort_next: led/busy/done/full=%b%b%b%b count=%0d ovf=%b required 0000 0 %b",
               led, busy, done, full, count, ovf, m_ovf);
    end
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (done || busy || led) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_quiet: activity=%b after abort, required 0", bad);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL abort_restart: busy=%b count=%0d required 0 0", busy, count);
    end
  endtask

  task automatic test_reset_gap();
    push(3'd4);
    push(3'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    checks++;
    if (busy !== 1'b1 || led !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL gap_pre: busy=%b led=%b count=%0d required 1 0 1", busy, led, count);
    end
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    m_ovf = 1'b0;
    checks++;
    if ({led, busy, done, full, count, ovf} !== 8'b0) begin
      errors++;
      $display("FAIL gap_reset: led/busy/done/full/count/ovf=%b%b%b%b_%0d_%b required all 0",
               led, busy, done, full, count, ovf);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || count !== '0 || led !== 1'b0) begin
      errors++;
      $display("FAIL gap_empty_start: busy=%b count=%0d led=%b required 0 0 0", busy, count, led);
    end
  endtask

  initial begin
    test_reset();
    test_single_letter();
    test_two_letters();
    test_queue_bounds();
    test_simultaneous();
    test_abort();
    test_reset_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/morse_sequencer.md
# morse_sequencer

Controller that sequences Morse playback of a queued message of letters A–H onto a single LED. Letter indexes are written into an internal queue. On `start`, the FSM pops each letter, looks up its element pattern, and shifts it out one bit per Morse unit from an internal tick divider. A 3-unit inter-letter gap follows each letter. It replaces the single-letter, key-loaded shifter path at the board top level.

## Interface
Parameters:
- `TICK_DIV`, 25000000: clock cycles per Morse unit (≥2).
- `DEPTH`, 8: queue entries (power of 2, ≥2).

Ports:
- `clock` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `wr_en` in 1: push `wr_data` into the queue this cycle.
- `wr_data` in 3: letter index (0=A … 7=H).
- `start` in 1: begin playback. Honoured only when IDLE and the queue is non-empty.
- `abort` in 1: synchronous stop and queue flush.
- `led` out 1: Morse output, registered.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse on normal completion.
- `full` out 1: queue holds `DEPTH` entries.
- `count` out $clog2(DEPTH)+1: current queue occupancy.
- `ovf` out 1: sticky; a write was dropped because the queue was full.

## Operation
- Pattern ROM (MSB first, length L):
  - A 10111/5
  - B 111010101/9
  - C 11101011101/11
  - D 1110101/7
  - E 1/1
  - F 101011101/9
  - G 111011101/9
  - H 1010101/7
- FSM states: IDLE, LOAD, SHIFT, GAP, DONE.
- IDLE:
  - `start` with `count`>0 → LOAD.
  - `start` with an empty queue is ignored.
- LOAD (1 cycle):
  - Pop the head entry.
  - Latch its pattern into a 12-bit shift register and L into a bit counter.
  - Load the divider with `TICK_DIV`-1.
  - `led`=0.
  - → SHIFT.
- SHIFT:
  - `led` = current pattern MSB.
  - Each tick (divider reaches 0; divider reloads `TICK_DIV`-1) shifts left and decrements the bit counter.
  - On the tick that consumes the last bit → GAP with a unit counter of 3.
- GAP:
  - `led`=0.
  - Each tick decrements the unit counter.
  - After the 3rd tick → LOAD if `count`>0, else DONE.
- DONE (1 cycle): `done`=1, → IDLE.
- Queue:
  - Circular buffer with read/write pointers wrapping modulo `DEPTH`.
  - Write when `full`: data dropped, `ovf` set, `count` unchanged.
  - Write and pop in the same cycle: both occur, `count` unchanged; a write to an empty queue is never popped that cycle.
  - Writes are accepted in every state, so the message may be extended while playing.
- `start` while `busy`: ignored.
- `abort`:
  - Highest synchronous priority.
  - Next cycle: state IDLE, `led`=0, queue emptied (`count`=0), no `done` pulse, `ovf` preserved.
  - A simultaneous `wr_en` is discarded.
- Reset values:
  - `led`=0, `busy`=0, `done`=0, `full`=0, `count`=0, `ovf`=0.
  - State IDLE, pointers 0, divider 0.
- Reset asserted mid-letter: outputs go to reset values immediately; the queue is lost.

## Timing
- `start` sampled high at edge T (IDLE, non-empty):
  - LOAD during T+1.
  - First bit on `led` from T+2.
- Each pattern bit is held exactly `TICK_DIV` cycles.
- A letter occupies L·`TICK_DIV` cycles, followed by a 3·`TICK_DIV`-cycle gap.
- Between consecutive letters, `led` is low for 3·`TICK_DIV`+1 cycles (GAP plus LOAD).
- Last letter:
  - `done` is high in the cycle after the final GAP cycle.
  - `busy` falls in the following cycle.
  - A new `start` is accepted from that cycle.
- `count` and `full` update the cycle after the push or pop edge.
- `ovf` sets the cycle after the dropped write.

## Test plan
All scenarios use `TICK_DIV`=4, `DEPTH`=4.
- Single letter: write 3'b100 (E), `start` at T:
  - `led`=1 on T+2..T+5, 0 on T+6..T+17.
  - `done` at T+18; `busy` low at T+19.
- Two letters: queue A then E, `start`:
  - `led` = 1,0,1,1,1 for 4 cycles each.
  - 13 low cycles.
  - 4 high cycles.
  - `done` after the final 12-cycle gap.
- Queue boundaries: 5 writes (A,B,C,D,E) in IDLE:
  - `count`=4, `full`=1, `ovf`=1 after the 5th write.
  - Playback emits A,B,C,D only.
- Simultaneous events:
  - Write during LOAD of the last entry: `count` unchanged, the new letter plays next.
  - `start` during SHIFT: ignored.
- Abort mid-letter during C with two entries queued:
  - Next cycle `led`=0, `busy`=0, `count`=0, no `done`.
  - A subsequent `start` is ignored.
- Async reset mid-GAP: all outputs 0 within the same cycle. `start` with an empty queue afterward is ignored.
